// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational ROM and
// hands {pc, inst} pairs to decode through a 2-entry fetch buffer.
module inst_fetch_ctrl #(
    parameter int NPC   = 6,
    parameter int NINST = 32,
    parameter int PCW   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_br_valid,
    input  logic [PCW-1:0]   i_br_target,
    output logic             o_rom_ce,
    output logic [NPC-1:0]   o_rom_addr,
    input  logic [NINST-1:0] i_rom_inst,
    output logic             o_id_valid,
    output logic [PCW-1:0]   o_id_pc,
    output logic [NINST-1:0] o_id_inst,
    input  logic             i_id_ready,
    output logic [PCW-1:0]   o_pc
);

    // state | meaning
    // IDLE  | one cycle after reset release, no fetch
    // RUN   | normal fetch / stall / redirect handling
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [PCW-1:0]   pc, pc_next;
    logic [1:0]       count, count_next;
    logic [PCW-1:0]   pc0, pc1;
    logic [NINST-1:0] inst0, inst1;
    logic             push, pop;
    logic             fill_head;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = count;
        pop        = 1'b0;
        push       = 1'b0;
        fill_head  = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN:  state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (i_br_valid) begin
            pc_next    = {i_br_target[PCW-1:2], 2'b00};
            count_next = '0;
        end else begin
            pop  = (count != 2'd0) && i_id_ready;
            push = (state == RUN) && !i_stall && ((count != 2'd2) || pop);
            if (push)
                pc_next = pc + PCW'(4);
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
            // New word lands in the head slot only if the head is (or becomes) empty.
            fill_head = push && ((count == 2'd0) || (count == 2'd1 && pop));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc0   <= '0;
            pc1   <= '0;
            inst0 <= '0;
            inst1 <= '0;
        end else begin
            if (pop && count == 2'd2) begin
                pc0   <= pc1;
                inst0 <= inst1;
            end
            if (fill_head) begin
                pc0   <= pc;
                inst0 <= i_rom_inst;
            end else if (push) begin
                pc1   <= pc;
                inst1 <= i_rom_inst;
            end
        end
    end

    assign o_rom_ce   = push;
    assign o_rom_addr = pc[NPC+1:2];
    assign o_id_valid = (count != 2'd0);
    assign o_id_pc    = pc0;
    assign o_id_inst  = inst0;
    assign o_pc       = pc;

endmodule
